// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, sequencer states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller.sv
// Eight-state instruction sequencer decoding opcode/zero into datapath strobes.
// Latency: outputs are combinational from current state; state advances once per clk.
// Backpressure: none; the sequence free-runs, halt is only advisory to the top level.
module controller
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    sel,
    output logic    rd,
    output logic    ld_ir,
    output logic    inc_pc,
    output logic    halt,
    output logic    ld_pc,
    output logic    data_e,
    output logic    ld_ac,
    output logic    wr
);

    state_t state;
    state_t next_state;
    logic   aluop;

    assign aluop = is_aluop(opcode);

    // State register; reset drops straight to INST_ADDR without waiting for a clock.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= INST_ADDR;
        end else begin
            state <= next_state;
        end
    end

    // Next state is a fixed ring; outputs decode current state plus live opcode/zero.
    always_comb begin
        next_state = INST_ADDR;
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        halt       = 1'b0;
        ld_pc      = 1'b0;
        data_e     = 1'b0;
        ld_ac      = 1'b0;
        wr         = 1'b0;
        unique case (state)
            INST_ADDR: begin
                next_state = INST_FETCH;
                sel        = 1'b1;
            end
            INST_FETCH: begin
                next_state = INST_LOAD;
                sel        = 1'b1;
                rd         = 1'b1;
            end
            INST_LOAD: begin
                next_state = IDLE;
                sel        = 1'b1;
                rd         = 1'b1;
                ld_ir      = 1'b1;
            end
            IDLE: begin
                next_state = OP_ADDR;
                sel        = 1'b1;
                rd         = 1'b1;
                ld_ir      = 1'b1;
            end
            OP_ADDR: begin
                next_state = OP_FETCH;
                inc_pc     = 1'b1;
                halt       = (opcode == HLT);
            end
            OP_FETCH: begin
                next_state = ALU_OP;
                rd         = aluop;
            end
            ALU_OP: begin
                next_state = STORE;
                rd         = aluop;
                inc_pc     = (opcode == SKZ) && zero;
                ld_pc      = (opcode == JMP);
                data_e     = (opcode == STO);
            end
            STORE: begin
                next_state = INST_ADDR;
                rd         = aluop;
                ld_ac      = aluop;
                inc_pc     = (opcode == JMP);
                ld_pc      = (opcode == JMP);
                wr         = (opcode == STO);
                data_e     = (opcode == STO);
            end
            default: begin
                next_state = INST_ADDR;
                sel        = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for the instruction sequencer.
// Expected output vectors are queued as stimulus is applied and compared mid-cycle.
// Vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}.
module tb_controller;
    import cpu_pkg::*;

    logic    clk;
    logic    rst_;
    opcode_t opcode;
    logic    zero;
    logic    sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

    int checks;
    int passed;
    int mstate;            // bench's own notion of the sequencer position, 0..7
    logic [8:0] exp_q[$];

    localparam logic [8:0] RESET_VEC = 9'b1_0000_0000;

    controller dut (
        .clk    (clk),
        .rst_   (rst_),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .halt   (halt),
        .ld_pc  (ld_pc),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
    endfunction

    // Reference decode written as a per-state truth table.
    function automatic logic [8:0] model(input int st, input opcode_t op, input logic z);
        logic reads;
        reads = (op == ADD) | (op == AND) | (op == XOR) | (op == LDA);
        case (st)
            0: return 9'b1_0000_0000;
            1: return 9'b1_1000_0000;
            2: return 9'b1_1100_0000;
            3: return 9'b1_1100_0000;
            4: return {3'b000, 1'b1, op == HLT, 4'b0000};
            5: return {1'b0, reads, 7'b0};
            6: return {1'b0, reads, 1'b0, (op == SKZ) & z, 1'b0, op == JMP, op == STO, 2'b00};
            default: return {1'b0, reads, 1'b0, op == JMP, 1'b0, op == JMP, op == STO, reads, op == STO};
        endcase
    endfunction

    // One cycle: drive inputs after the edge, queue expectation, compare at the falling edge.
    task automatic step(input opcode_t op, input logic z, input string name);
        logic [8:0] e;
        logic [8:0] got;
        opcode = op;
        zero   = z;
        exp_q.push_back(model(mstate, op, z));
        @(negedge clk);
        got = outs();
        e = exp_q.pop_front();
        checks++;
        if (got !== e)
            $display("FAIL %s op=%0d state=%0d got=%b want=%b", name, op, mstate, got, e);
        else
            passed++;
        checks++;
        if ((rd & wr) !== 1'b0)
            $display("FAIL %s rd_wr_exclusive got rd=%b wr=%b want not both", name, rd, wr);
        else
            passed++;
        @(posedge clk);
        #1;
        mstate = (mstate + 1) % 8;
    endtask

    task automatic run_instr(input opcode_t op, input logic z, input string name);
        for (int i = 0; i < 8; i++) step(op, z, name);
    endtask

    task automatic test_reset;
        rst_   = 1'b0;
        opcode = ADD;
        zero   = 1'b0;
        #13;
        checks++;
        if (outs() !== RESET_VEC)
            $display("FAIL reset_outputs got=%b want=%b", outs(), RESET_VEC);
        else
            passed++;
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        mstate = 0;     // first edge after release was consumed before stepping; realign
        // release happened at a negedge so the edge above moved INST_ADDR->INST_FETCH
        mstate = 1;
        // back up: redo release so the ADD instruction starts cleanly at INST_ADDR
        rst_ = 1'b0;
        #1;
        rst_ = 1'b1;
        mstate = 0;
    endtask

    task automatic test_add;
        run_instr(ADD, 1'b0, "add");
        // wrap back to INST_ADDR
        step(ADD, 1'b0, "add_wrap");
        run_instr(ADD, 1'b0, "add_b2b_tail");  // finishes the 8-cycle frame offset by one
    endtask

    task automatic realign;
        while (mstate != 0) step(LDA, 1'b0, "realign");
    endtask

    task automatic test_hlt;     run_instr(HLT, 1'b0, "hlt");      endtask
    task automatic test_skz;
        run_instr(SKZ, 1'b1, "skz_z1");
        run_instr(SKZ, 1'b0, "skz_z0");
    endtask
    task automatic test_jmp;     run_instr(JMP, 1'b0, "jmp");      endtask
    task automatic test_sto;     run_instr(STO, 1'b1, "sto");      endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) step(XOR, 1'b0, "pre_reset");
        // now in OP_FETCH (mstate==5); pulse reset with no clock edge
        opcode = XOR;
        #2;
        rst_ = 1'b0;
        #1;
        checks++;
        if (outs() !== RESET_VEC)
            $display("FAIL reset_mid_async got=%b want=%b", outs(), RESET_VEC);
        else
            passed++;
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        checks++;
        if (outs() !== RESET_VEC)
            $display("FAIL reset_mid_release got=%b want=%b", outs(), RESET_VEC);
        else
            passed++;
        @(posedge clk);
        #1;
        checks++;
        if (outs() !== model(1, XOR, 1'b0))
            $display("FAIL reset_mid_first_edge got=%b want=%b", outs(), model(1, XOR, 1'b0));
        else
            passed++;
        mstate = 1;
    endtask

    task automatic test_random_opcodes;
        for (int i = 0; i < 64; i++)
            step(opcode_t'($urandom_range(7)), 1'($urandom_range(1)), "random");
    endtask

    initial begin
        checks = 0;
        passed = 0;
        mstate = 0;
        test_reset();
        test_add();
        realign();
        test_hlt();
        test_skz();
        test_jmp();
        test_sto();
        test_reset_mid();
        realign();
        test_random_opcodes();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
